// File: rtl/line_window_buffer_if.sv
// Pixel stream bundle for line_window_buffer: raw video in, delayed syncs plus a vertical tap column out.
interface line_window_buffer_if #(
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3,
   parameter int LINES    = 5
);
   logic [CHANNELS*DATA_W-1:0]       data_i;
   logic                             dv_i;
   logic                             hs_i;
   logic                             vs_i;
   logic                             dv_o;
   logic                             hs_o;
   logic                             vs_o;
   logic [LINES*CHANNELS*DATA_W-1:0] taps_o;
   logic [LINES-1:0]                 tap_valid_o;
   logic                             ovf_o;

   modport master (
      output data_i, dv_i, hs_i, vs_i,
      input  dv_o, hs_o, vs_o, taps_o, tap_valid_o, ovf_o
   );

   modport slave (
      input  data_i, dv_i, hs_i, vs_i,
      output dv_o, hs_o, vs_o, taps_o, tap_valid_o, ovf_o
   );
endinterface

// File: rtl/line_window_buffer.sv
// Multi-line window buffer: presents LINES vertically stacked pixels per input pixel, 2-cycle latency.
// Build option LINE_WINDOW_BORDER_REPLICATE_EN: invalid taps repeat the oldest valid tap instead of zero.
module line_window_buffer #(
   parameter int DATA_W     = 8,
   parameter int CHANNELS   = 3,
   parameter int LINE_W_MAX = 1600,
   parameter int LINES      = 5,
   parameter int ADDR_W     = 11
) (
   input logic                 clk,
   input logic                 rst,
   line_window_buffer_if.slave pix
);
   localparam int PIX_W = CHANNELS * DATA_W;
   localparam int LC_W  = $clog2(LINES);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_W_MAX - 1);
   localparam logic [LC_W-1:0]   LC_LAST  = LC_W'(LINES - 1);

   logic [PIX_W-1:0]       mem    [LINES-1][LINE_W_MAX];
   logic [PIX_W-1:0]       mem_rd [LINES-1];
   logic [PIX_W-1:0]       win    [LINES];
   logic [PIX_W-1:0]       s1_pix;
   logic [ADDR_W-1:0]      col;
   logic [LC_W-1:0]        lc;
   logic [LC_W-1:0]        lc_now;
   logic [LC_W-1:0]        s1_lc;
   logic                   dv_prev;
   logic                   vs_prev;
   logic                   line_ok;
   logic                   s1_dv;
   logic                   s1_hs;
   logic                   s1_vs;
   logic                   vs_rise;
   logic                   dv_fall;
   logic [LINES-1:0]       valid_c;
   logic [LINES*PIX_W-1:0] taps_c;

   assign vs_rise = pix.vs_i & ~vs_prev;
   assign dv_fall = dv_prev & ~pix.dv_i;
   assign lc_now  = vs_rise ? '0 : lc;

   // Each memory hands its old pixel at this column to the next one while taking the new pixel.
   always_ff @(posedge clk) begin
      for (int m = 0; m < LINES-1; m++) mem_rd[m] <= mem[m][col];
      if (pix.dv_i && !rst) begin
         mem[0][col] <= pix.data_i;
         for (int m = 1; m < LINES-1; m++) mem[m][col] <= mem[m-1][col];
      end
   end

   always_comb begin
      win[0] = s1_pix;
      for (int k = 1; k < LINES; k++) win[k] = mem_rd[k-1];
   end

   // Taps older than the lines seen in this frame are masked with zero or the oldest valid row.
   always_comb begin
      valid_c = '0;
      taps_c  = '0;
      if (s1_dv) begin
         for (int k = 0; k < LINES; k++) begin
            if (LC_W'(k) <= s1_lc) begin
               valid_c[k]               = 1'b1;
               taps_c[k*PIX_W +: PIX_W] = win[k];
            end else begin
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
               taps_c[k*PIX_W +: PIX_W] = win[s1_lc];
`else
               taps_c[k*PIX_W +: PIX_W] = '0;
`endif
            end
         end
      end
   end

   // line_ok keeps a line that was already running when reset dropped from being counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         col             <= '0;
         lc              <= '0;
         dv_prev         <= 1'b0;
         vs_prev         <= 1'b0;
         line_ok         <= 1'b0;
         s1_pix          <= '0;
         s1_dv           <= 1'b0;
         s1_hs           <= 1'b0;
         s1_vs           <= 1'b0;
         s1_lc           <= '0;
         pix.dv_o        <= 1'b0;
         pix.hs_o        <= 1'b0;
         pix.vs_o        <= 1'b0;
         pix.taps_o      <= '0;
         pix.tap_valid_o <= '0;
         pix.ovf_o       <= 1'b0;
      end else begin
         dv_prev <= pix.dv_i;
         vs_prev <= pix.vs_i;
         if (!pix.dv_i) line_ok <= 1'b1;

         if (!pix.dv_i) col <= '0;
         else if (col != COL_LAST) col <= col + 1'b1;

         if (vs_rise) lc <= '0;
         else if (dv_fall && line_ok && lc != LC_LAST) lc <= lc + 1'b1;

         if (vs_rise) pix.ovf_o <= 1'b0;
         else if (pix.dv_i && col == COL_LAST) pix.ovf_o <= 1'b1;

         s1_pix <= pix.data_i;
         s1_dv  <= pix.dv_i;
         s1_hs  <= pix.hs_i;
         s1_vs  <= pix.vs_i;
         s1_lc  <= lc_now;

         pix.dv_o        <= s1_dv;
         pix.hs_o        <= s1_hs;
         pix.vs_o        <= s1_vs;
         pix.taps_o      <= taps_c;
         pix.tap_valid_o <= valid_c;
      end
   end
endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: directed frames plus random sync/valid traffic against
// a per-column history model of the line window.
module tb_line_window_buffer;
   localparam int DATA_W   = 8;
   localparam int CHANNELS = 3;
   localparam int LINES    = 5;
   localparam int LMAX     = 16;
   localparam int PIX_W    = DATA_W * CHANNELS;
   localparam int TAPS_W   = LINES * PIX_W;

   typedef struct {
      logic              dv;
      logic              hs;
      logic              vs;
      logic [LINES-1:0]  valid;
      logic [TAPS_W-1:0] taps;
      logic [TAPS_W-1:0] care;
      int                ph;
      int                ln;
      int                cl;
   } exp_t;

   logic clk;
   logic rst;

   line_window_buffer_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .LINES(LINES)) pix ();

   line_window_buffer #(
      .DATA_W(DATA_W), .CHANNELS(CHANNELS), .LINE_W_MAX(LMAX), .LINES(LINES), .ADDR_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pix(pix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   // Model state: every column remembers the pixels last written to it, newest first.
   logic [PIX_W-1:0] hist  [LMAX][LINES-1];
   bit               known [LMAX][LINES-1];
   exp_t             q[$];
   int               pix_idx_m;
   int               lc_m;
   bit               seen_low_m;
   bit               dv_prev_m;
   bit               vs_prev_m;
   bit               ovf_m;
   bit               armed;
   int               cur_ph;
   int               cur_ln;
   int               cur_cl;

   function automatic logic [PIX_W-1:0] pixOf(input logic [7:0] b);
      return {b ^ 8'hAA, b ^ 8'h55, b};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic exp_t zeroEntry();
      exp_t e;
      e.dv = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
      e.valid = '0; e.taps = '0; e.care = '1;
      e.ph = 0; e.ln = -1; e.cl = -1;
      return e;
   endfunction

   task automatic modelReset();
      q.delete();
      q.push_back(zeroEntry());
      q.push_back(zeroEntry());
      pix_idx_m  = 0;
      lc_m       = 0;
      seen_low_m = 1'b0;
      dv_prev_m  = 1'b0;
      vs_prev_m  = 1'b0;
      ovf_m      = 1'b0;
      armed      = 1'b1;
   endtask

   task automatic modelStep(input logic [PIX_W-1:0] d, input logic dv, input logic hs, input logic vs);
      exp_t             e;
      logic [PIX_W-1:0] tv [LINES];
      bit               tk [LINES];
      bit               vs_rise;
      int               c;
      vs_rise = vs && !vs_prev_m;
      if (vs_rise) lc_m = 0;
      e = zeroEntry();
      e.dv = dv; e.hs = hs; e.vs = vs;
      e.ph = cur_ph; e.ln = cur_ln; e.cl = cur_cl;
      if (dv) begin
         c = (pix_idx_m < LMAX) ? pix_idx_m : LMAX - 1;
         tv[0] = d;
         tk[0] = 1'b1;
         for (int k = 1; k < LINES; k++) begin
            tv[k] = hist[c][k-1];
            tk[k] = known[c][k-1];
         end
         for (int k = 0; k < LINES; k++) begin
            int src;
            src = (k <= lc_m) ? k : -1;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
            if (src < 0) src = lc_m;
`endif
            e.valid[k] = (k <= lc_m);
            if (src >= 0) begin
               e.taps[k*PIX_W +: PIX_W] = tv[src];
               if (!tk[src]) e.care[k*PIX_W +: PIX_W] = '0;
            end
         end
         for (int k = LINES - 2; k >= 1; k--) begin
            hist[c][k]  = hist[c][k-1];
            known[c][k] = known[c][k-1];
         end
         hist[c][0]  = d;
         known[c][0] = 1'b1;
         if (vs_rise) ovf_m = 1'b0;
         else if (pix_idx_m >= LMAX - 1) ovf_m = 1'b1;
         pix_idx_m++;
      end else begin
         if (vs_rise) ovf_m = 1'b0;
         if (dv_prev_m && seen_low_m && lc_m < LINES - 1) lc_m++;
         seen_low_m = 1'b1;
         pix_idx_m  = 0;
      end
      dv_prev_m = dv;
      vs_prev_m = vs;
      q.push_back(e);
   endtask

   task automatic verifyCycle();
      exp_t e;
      if (q.size() == 2) begin
         e = q.pop_front();
         checkOutput("sync", 128'({pix.vs_o, pix.hs_o, pix.dv_o}), 128'({e.vs, e.hs, e.dv}));
         checkOutput("tap_valid", 128'(pix.tap_valid_o), 128'(e.valid));
         checkOutput("taps", 128'(pix.taps_o & e.care), 128'(e.taps & e.care));
         if (e.dv && e.ph == 1 && e.ln == 4 && e.cl == 3) begin
            checkOutput("full_window", 128'(pix.taps_o),
               128'({pixOf(8'h03), pixOf(8'h13), pixOf(8'h23), pixOf(8'h33), pixOf(8'h43)}));
            checkOutput("full_valid", 128'(pix.tap_valid_o), 128'(5'b11111));
         end
         if (e.dv && e.ph == 1 && e.ln == 1 && e.cl == 2) begin
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
            checkOutput("first_frame_taps", 128'(pix.taps_o),
               128'({pixOf(8'h02), pixOf(8'h02), pixOf(8'h02), pixOf(8'h02), pixOf(8'h12)}));
`else
            checkOutput("first_frame_taps", 128'(pix.taps_o),
               128'({72'h0, pixOf(8'h02), pixOf(8'h12)}));
`endif
            checkOutput("first_frame_valid", 128'(pix.tap_valid_o), 128'(5'b00011));
         end
         if (e.dv && e.ph == 3 && e.cl == 1 && e.ln < 2)
            checkOutput("new_frame_valid", 128'(pix.tap_valid_o), (e.ln == 0) ? 128'(5'b00001) : 128'(5'b00011));
         if (e.dv && e.ph == 6 && e.ln == 0 && e.cl == 0)
            checkOutput("post_reset_valid", 128'(pix.tap_valid_o), 128'(5'b00001));
      end
      if (armed) checkOutput("ovf", 128'(pix.ovf_o), 128'(ovf_m));
   endtask

   task automatic applyStimulus(input logic [PIX_W-1:0] d, input logic dv, input logic hs,
                                input logic vs, input logic r);
      pix.data_i = d;
      pix.dv_i   = dv;
      pix.hs_i   = hs;
      pix.vs_i   = vs;
      rst        = r;
      if (r) modelReset();
      else modelStep(d, dv, hs, vs);
      @(posedge clk);
      #1;
      verifyCycle();
   endtask

   task automatic blank(input int n, input int vs_at);
      cur_ln = -1;
      cur_cl = -1;
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, (i == 1), (i == vs_at), 1'b0);
   endtask

   task automatic sendLine(input int ln, input int width, input int base, input bit vs_first);
      for (int c = 0; c < width; c++) begin
         cur_ln = ln;
         cur_cl = c;
         applyStimulus(pixOf(8'(base + ln * 16 + c)), 1'b1, 1'b0, vs_first && (c == 0), 1'b0);
      end
   endtask

   initial begin
      int cycles;
      int act_len;
      int blk_len;
      logic vs_cur;
      logic v;

      armed = 1'b0;
      cur_ph = 0; cur_ln = -1; cur_cl = -1;
      for (int c = 0; c < LMAX; c++)
         for (int k = 0; k < LINES - 1; k++) begin
            known[c][k] = 1'b0;
            hist[c][k]  = '0;
         end
      pix.data_i = '0; pix.dv_i = 1'b0; pix.hs_i = 1'b0; pix.vs_i = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
      blank(4, -1);

      cur_ph = 1;
      blank(4, 1);
      for (int ln = 0; ln < 6; ln++) begin
         sendLine(ln, 8, 0, 1'b0);
         blank(4, -1);
      end

      cur_ph = 3;
      blank(3, -1);
      for (int ln = 0; ln < 3; ln++) begin
         sendLine(ln, 8, 8'h80, (ln == 0));
         blank(4, -1);
      end

      cur_ph = 4;
      sendLine(0, 20, 8'h40, 1'b0);
      blank(6, -1);
      checkOutput("ovf_sticky", 128'(pix.ovf_o), 128'(1'b1));
      blank(4, 1);
      checkOutput("ovf_cleared", 128'(pix.ovf_o), 128'(1'b0));

      cur_ph = 5;
      sendLine(0, 8, 8'h20, 1'b0);
      blank(4, -1);
      for (int c = 0; c < 8; c++) begin
         cur_ln = 1;
         cur_cl = c;
         applyStimulus(pixOf(8'(8'h30 + c)), 1'b1, 1'b0, 1'b0, (c == 4));
      end
      blank(4, -1);
      cur_ph = 6;
      sendLine(0, 8, 8'h60, 1'b0);
      blank(4, -1);
      sendLine(1, 8, 8'h60, 1'b0);
      blank(4, -1);

      cur_ph = 7;
      cycles = 0;
      vs_cur = 1'b0;
      while (cycles < 2500) begin
         act_len = $urandom_range(1, 20);
         blk_len = $urandom_range(1, 5);
         for (int i = 0; i < act_len + blk_len; i++) begin
            logic dv;
            dv = (i < act_len);
            if ($urandom_range(0, 11) == 0) vs_cur = ~vs_cur;
            v = vs_cur;
            if (v && !vs_prev_m && ((dv_prev_m && !dv) || (dv && pix_idx_m >= LMAX - 1))) v = 1'b0;
            cur_ln = -1;
            cur_cl = -1;
            applyStimulus(PIX_W'($urandom), dv, 1'($urandom), v, ($urandom_range(0, 399) == 0));
            cycles++;
         end
      end
      blank(3, -1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
